// File: rtl/iot_tty_device_pkg.sv
// Shared definitions for the console teletype device.
// Contents:
//   prn_state_e        printer FSM states
//   KSF/KCC/KRS/KRB    keyboard IOT pulse-bit patterns
//   TSF/TCF/TPC/TLS    printer IOT pulse-bit patterns
//   *_DEV_DEFAULT      default device codes
//   op_hit()           tests whether all bits of a pulse mask are set in an op field
package iot_tty_device_pkg;

   typedef enum logic [1:0] {
      PRN_IDLE = 2'd0,
      PRN_SEND = 2'd1,
      PRN_BUSY = 2'd2
   } prn_state_e;

   localparam logic [2:0] KSF = 3'b001;
   localparam logic [2:0] KCC = 3'b010;
   localparam logic [2:0] KRS = 3'b100;
   localparam logic [2:0] KRB = 3'b110;

   localparam logic [2:0] TSF = 3'b001;
   localparam logic [2:0] TCF = 3'b010;
   localparam logic [2:0] TPC = 3'b100;
   localparam logic [2:0] TLS = 3'b110;

   localparam logic [5:0] KBD_DEV_DEFAULT = 6'o03;
   localparam logic [5:0] PRN_DEV_DEFAULT = 6'o04;

   localparam int unsigned KBD_FIFO_DEPTH = 4;

   function automatic logic op_hit(input logic [2:0] op, input logic [2:0] mask);
      return (op & mask) == mask;
   endfunction

endpackage

// File: rtl/iot_tty_device_if.sv
// IOT distributor bus between the CPU and a device.
// Signals:
//   iot_req      CPU -> dev  one-cycle strobe, IOT instruction present
//   iot_dev      CPU -> dev  device code (instruction bits [8:3])
//   iot_op       CPU -> dev  pulse bits (instruction bits [2:0])
//   iot_dataout  CPU -> dev  AC[7:0]
//   iot_ack      dev -> CPU  response valid, one cycle
//   iot_datain   dev -> CPU  data ORed into AC
//   iot_skip     dev -> CPU  skip next instruction
//   iot_clr_ac   dev -> CPU  clear AC before the OR
// Modports: master (CPU side), slave (device side).
interface iot_tty_device_if;

   logic       iot_req;
   logic [5:0] iot_dev;
   logic [2:0] iot_op;
   logic [7:0] iot_dataout;
   logic       iot_ack;
   logic [7:0] iot_datain;
   logic       iot_skip;
   logic       iot_clr_ac;

   modport master (
      output iot_req, iot_dev, iot_op, iot_dataout,
      input  iot_ack, iot_datain, iot_skip, iot_clr_ac
   );

   modport slave (
      input  iot_req, iot_dev, iot_op, iot_dataout,
      output iot_ack, iot_datain, iot_skip, iot_clr_ac
   );

endinterface

// File: rtl/iot_tty_device_fifo.sv
// tty_fifo: small synchronous FIFO used as the keyboard buffer when TTY_KBD_FIFO_EN
// is defined. Synchronous active-high reset.
// Ports:
//   clk_i, rst_i   clock / reset
//   push_i         write wdata_i (ignored when full)
//   pop_i          drop head entry (ignored when empty)
//   wdata_i        write data
//   rdata_o        head entry, 0 when empty
//   full_o         no free entry
//   empty_o        no valid entry
module tty_fifo #(
   parameter int unsigned Depth = 4,
   parameter int unsigned Width = 8
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             push_i,
   input  logic             pop_i,
   input  logic [Width-1:0] wdata_i,
   output logic [Width-1:0] rdata_o,
   output logic             full_o,
   output logic             empty_o
);

   localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
   localparam logic [PtrW:0] DepthCnt = (PtrW + 1)'(Depth);

   logic [Width-1:0] mem_q [Depth];
   logic [PtrW-1:0]  wptr_q, wptr_d, rptr_q, rptr_d;
   logic [PtrW:0]    cnt_q, cnt_d;
   logic             do_push, do_pop;

   function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
      return (p == PtrW'(Depth - 1)) ? '0 : p + PtrW'(1);
   endfunction

   assign full_o  = (cnt_q == DepthCnt);
   assign empty_o = (cnt_q == '0);
   assign do_push = push_i && !full_o;
   assign do_pop  = pop_i && !empty_o;
   assign rdata_o = empty_o ? '0 : mem_q[rptr_q];

   always_comb begin
      wptr_d = do_push ? ptr_inc(wptr_q) : wptr_q;
      rptr_d = do_pop ? ptr_inc(rptr_q) : rptr_q;
      cnt_d  = cnt_q;
      if (do_push && !do_pop) cnt_d = cnt_q + (PtrW + 1)'(1);
      if (!do_push && do_pop) cnt_d = cnt_q - (PtrW + 1)'(1);
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wptr_q <= '0;
         rptr_q <= '0;
         cnt_q  <= '0;
      end else begin
         wptr_q <= wptr_d;
         rptr_q <= rptr_d;
         cnt_q  <= cnt_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (do_push) mem_q[wptr_q] <= wdata_i;
   end

endmodule

// File: rtl/iot_tty_device.sv
// iot_tty_device: PDP-8 console teletype on the IOT bus (keyboard + printer).
// Build option: TTY_KBD_FIFO_EN selects a 4-entry keyboard FIFO instead of a
// single-character buffer.
// Ports:
//   clock, reset    system clock, synchronous active-high reset
//   iot             IOT bus, slave side (registered 1-cycle response)
//   kbd_valid/data  host offers a keyboard character
//   kbd_ready       device can accept a keyboard character
//   prn_valid/data  device offers a printed character, held until prn_ready
//   prn_ready       host accepts the printed character
//   prn_overrun     sticky: print issued while printer was busy
module iot_tty_device
   import iot_tty_device_pkg::*;
#(
   parameter logic [5:0]  KBD_DEV   = KBD_DEV_DEFAULT,
   parameter logic [5:0]  PRN_DEV   = PRN_DEV_DEFAULT,
   parameter int unsigned PRN_DELAY = 16
) (
   input  logic                   clock,
   input  logic                   reset,
   iot_tty_device_if.slave        iot,
   input  logic                   kbd_valid,
   input  logic [7:0]             kbd_data,
   output logic                   kbd_ready,
   output logic                   prn_valid,
   output logic [7:0]             prn_data,
   input  logic                   prn_ready,
   output logic                   prn_overrun
);

   localparam int unsigned CntW = $clog2(PRN_DELAY + 1);

   logic       kbd_sel, prn_sel;
   logic       ksf, kcc, krs, tsf, tcf, tpc;
   logic       kbd_flag;
   logic [7:0] kbd_buf;

   assign kbd_sel = iot.iot_req && (iot.iot_dev == KBD_DEV);
   assign prn_sel = iot.iot_req && (iot.iot_dev == PRN_DEV);
   assign ksf     = kbd_sel && op_hit(iot.iot_op, KSF);
   assign kcc     = kbd_sel && op_hit(iot.iot_op, KCC);
   assign krs     = kbd_sel && op_hit(iot.iot_op, KRS);
   assign tsf     = prn_sel && op_hit(iot.iot_op, TSF);
   assign tcf     = prn_sel && op_hit(iot.iot_op, TCF);
   assign tpc     = prn_sel && op_hit(iot.iot_op, TPC);

   // ---------------- keyboard buffer ----------------
`ifdef TTY_KBD_FIFO_EN
   logic fifo_full, fifo_empty;

   // A pop on an empty FIFO is ignored, so KCC alongside the first push keeps the flag set.
   tty_fifo #(
      .Depth (KBD_FIFO_DEPTH),
      .Width (8)
   ) u_kbd_fifo (
      .clk_i   (clock),
      .rst_i   (reset),
      .push_i  (kbd_valid),
      .pop_i   (kcc),
      .wdata_i (kbd_data),
      .rdata_o (kbd_buf),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

   assign kbd_ready = !fifo_full;
   assign kbd_flag  = !fifo_empty;
`else
   logic       kbd_flag_q, kbd_flag_d;
   logic [7:0] kbd_buf_q, kbd_buf_d;
   logic       kbd_hs;

   assign kbd_ready = !kbd_flag_q;
   assign kbd_hs    = kbd_valid && kbd_ready;

   // Load beats KCC in the same cycle.
   always_comb begin
      kbd_flag_d = kbd_flag_q;
      kbd_buf_d  = kbd_buf_q;
      if (kcc) kbd_flag_d = 1'b0;
      if (kbd_hs) begin
         kbd_flag_d = 1'b1;
         kbd_buf_d  = kbd_data;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         kbd_flag_q <= 1'b0;
         kbd_buf_q  <= '0;
      end else begin
         kbd_flag_q <= kbd_flag_d;
         kbd_buf_q  <= kbd_buf_d;
      end
   end

   assign kbd_flag = kbd_flag_q;
   assign kbd_buf  = kbd_buf_q;
`endif

   // ---------------- printer ----------------
   prn_state_e      state_q, state_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic [7:0]      prn_data_q, prn_data_d;
   logic            prn_flag_q, prn_flag_d;
   logic            overrun_q, overrun_d;
   // TPC is staged one cycle so the FSM acts alongside the registered ack.
   logic            tpc_pend_q;
   logic [7:0]      tpc_data_q;

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      prn_data_d = prn_data_q;
      prn_flag_d = prn_flag_q;
      overrun_d  = overrun_q;
      if (tcf) prn_flag_d = 1'b0;
      if (tpc_pend_q && (state_q != PRN_IDLE)) overrun_d = 1'b1;
      unique case (state_q)
         PRN_IDLE: begin
            if (tpc_pend_q) begin
               state_d    = PRN_SEND;
               prn_data_d = tpc_data_q;
            end
         end
         PRN_SEND: begin
            if (prn_ready) begin
               state_d = PRN_BUSY;
               cnt_d   = CntW'(PRN_DELAY);
            end
         end
         PRN_BUSY: begin
            cnt_d = cnt_q - CntW'(1);
            // Counter reaches 0 here; flag set overrides a same-cycle TCF.
            if (cnt_q == CntW'(1)) begin
               state_d    = PRN_IDLE;
               prn_flag_d = 1'b1;
            end
         end
         default: state_d = PRN_IDLE;
      endcase
   end

   // ---------------- IOT response ----------------
   logic       ack_q, skip_q, clr_ac_q;
   logic       ack_d, skip_d, clr_ac_d;
   logic [7:0] datain_q, datain_d;

   // Skip sees flags before any clear carried by the same instruction.
   always_comb begin
      ack_d    = kbd_sel || prn_sel;
      skip_d   = (ksf && kbd_flag) || (tsf && prn_flag_q);
      clr_ac_d = kcc;
      datain_d = krs ? kbd_buf : '0;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q    <= PRN_IDLE;
         cnt_q      <= '0;
         prn_data_q <= '0;
         prn_flag_q <= 1'b0;
         overrun_q  <= 1'b0;
         tpc_pend_q <= 1'b0;
         tpc_data_q <= '0;
         ack_q      <= 1'b0;
         skip_q     <= 1'b0;
         clr_ac_q   <= 1'b0;
         datain_q   <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         prn_data_q <= prn_data_d;
         prn_flag_q <= prn_flag_d;
         overrun_q  <= overrun_d;
         tpc_pend_q <= tpc;
         tpc_data_q <= iot.iot_dataout;
         ack_q      <= ack_d;
         skip_q     <= skip_d;
         clr_ac_q   <= clr_ac_d;
         datain_q   <= datain_d;
      end
   end

   assign prn_valid      = (state_q == PRN_SEND);
   assign prn_data       = prn_data_q;
   assign prn_overrun    = overrun_q;
   assign iot.iot_ack    = ack_q;
   assign iot.iot_skip   = skip_q;
   assign iot.iot_clr_ac = clr_ac_q;
   assign iot.iot_datain = datain_q;

endmodule

// File: doc/iot_tty_device.md
# iot_tty_device

Console teletype device for the PDP-8 simulator, sitting directly downstream of the CPU's IOT distributor port. It decodes IOT instructions for device 03 (keyboard) and device 04 (printer). It returns skip, clear-AC and read data to the CPU, and exchanges characters with a host-side byte stream through valid/ready handshakes. The printer path models finite print time with a busy counter before raising its flag.

## Interface
Parameters:
- KBD_DEV, 6'o03, keyboard device code
- PRN_DEV, 6'o04, printer device code
- PRN_DELAY, 16, busy cycles after a character is handed to the host, before the printer flag sets (≥1)

Ports (one clock; reset is synchronous and active-high):
- clock  input  1  system clock, all state updates on posedge
- reset  input  1  synchronous, active-high reset
- iot_req  input  1  one-cycle strobe: IOT instruction present
- iot_dev  input  6  instruction bits [8:3], device code
- iot_op  input  3  instruction bits [2:0], pulse bits
- iot_dataout  input  8  AC[7:0] from CPU
- iot_ack  output  1  response valid, one cycle
- iot_datain  output  8  data to OR into AC
- iot_skip  output  1  skip next instruction
- iot_clr_ac  output  1  clear AC before OR
- kbd_valid  input  1  host offers a character
- kbd_data  input  8  host character
- kbd_ready  output  1  device can accept a character
- prn_valid  output  1  device offers a printed character
- prn_data  output  8  printed character
- prn_ready  input  1  host accepts character
- prn_overrun  output  1  sticky: print issued while printer busy

## Operation
- Decode only when iot_req=1 and iot_dev matches KBD_DEV or PRN_DEV. Other devices get no ack; all outputs stay 0.
- Keyboard (op bits act independently, combined in one instruction):
  - op[0] KSF: skip if kbd_flag.
  - op[1] KCC: clear AC, clear kbd_flag.
  - op[2] KRS: datain = kbd_buf.
  - KRB = 3'b110: clear AC, read buffer, clear flag.
- Keyboard buffer: single 8-bit kbd_buf. kbd_ready = ~kbd_flag. A handshake (kbd_valid & kbd_ready) loads kbd_buf and sets kbd_flag.
- Printer:
  - op[0] TSF: skip if prn_flag.
  - op[1] TCF: clear prn_flag.
  - op[2] TPC: latch iot_dataout, start print.
  - TLS = 3'b110: clear flag and print.
- Printer FSM:
  - IDLE: on TPC go to SEND with prn_data latched.
  - SEND: prn_valid=1, hold data stable until prn_ready; then go to BUSY and load counter with PRN_DELAY.
  - BUSY: decrement the counter; at 0, set prn_flag and go to IDLE.
- TPC in SEND or BUSY: data dropped, FSM unaffected, prn_overrun←1. prn_overrun is cleared only by reset.
- Simultaneous events:
  - KCC on the same cycle as a keyboard handshake: the load wins and the flag stays set.
  - TCF on the same cycle the busy counter expires: the flag sets.

## Timing
- Response latency is exactly 1 cycle. iot_ack/iot_datain/iot_skip/iot_clr_ac are registered and valid on the cycle after iot_req, for one cycle. Outside ack they are 0.
- Skip is evaluated on flag values before any clear in the same instruction.
- Back-to-back iot_req on consecutive cycles is supported. Each gets its own ack.
- prn_flag sets exactly PRN_DELAY+1 cycles after the prn_valid&prn_ready cycle.
- Reset values:
  - All outputs 0.
  - kbd_flag=0, prn_flag=0, FSM=IDLE, counter=0, kbd_buf=0.
  - kbd_ready is 1 from the first cycle after reset.
- Reset mid-print: FSM returns to IDLE and prn_valid drops the next cycle. The character is lost and no flag is raised.

## Configuration
- TTY_KBD_FIFO_EN defined:
  - The keyboard buffer is a 4-entry FIFO.
  - kbd_ready = FIFO not full.
  - kbd_flag = FIFO not empty.
  - KRS reads the head entry.
  - KCC pops one entry; the flag stays set if more entries remain.
- Undefined: single-entry buffer as above.
- CPU-side behaviour is identical when at most one character is pending.

## Structure
- Shared package:
  - printer FSM state enum (PRN_IDLE, PRN_SEND, PRN_BUSY)
  - keyboard op-bit constants KSF/KCC/KRS/KRB
  - printer op-bit constants TSF/TCF/TPC/TLS
  - default device codes
- Sub-module tty_fifo (parameterised depth/width, push/pop/full/empty) is instantiated only under TTY_KBD_FIFO_EN.

## Test plan
- Reset, then KSF (dev 03, op 001): ack next cycle, skip=0, clr_ac=0, datain=0.
- Host sends 8'h41; then KRB (op 110): ack with datain=8'h41, clr_ac=1, skip=0. A following KSF gives skip=0 and kbd_ready=1.
- TLS with dataout=8'h5A, PRN_DELAY=16:
  - prn_valid rises 2 cycles after the request with prn_data=8'h5A.
  - With prn_ready held, TSF skips only from 17 cycles after the handshake.
- TPC issued while in BUSY: prn_data unchanged, prn_overrun=1 until reset.
- iot_req with dev 05: no ack. KSF and TSF issued on consecutive cycles: two consecutive acks with correct skips.
- With TTY_KBD_FIFO_EN, push 5 chars:
  - the 5th stalls (kbd_ready=0).
  - four KRB reads return the chars in order.
  - the flag clears after the 4th.
